fp_addsub_stream: RTL and testbench
===================================

# fp_addsub_stream

Streaming front/back end for the combinational `ip_fp_addsub` core. It accepts operand tokens `{a, b, op, rnd}` over a valid/ready handshake and holds them in an issue register that drives the core. It captures the core's `z` and `status` into a result FIFO and presents them downstream over valid/ready. It also keeps sticky exception flags and a result counter for the surrounding datapath.

## Interface
- `P_EXP`, 5, exponent width (half precision)
- `P_FRAC`, 10, fraction width
- `P_BIAS`, 15, exponent bias; passed through to the package, not used in logic
- `P_WORD`, `1+P_EXP+P_FRAC`, operand/result width
- `P_DEPTH`, 4, result FIFO depth; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_vld`  in  1  operand token valid
- `in_rdy`  out  1  token accepted when `in_vld && in_rdy`
- `in_a`, `in_b`  in  P_WORD  operands
- `in_op`  in  1  0 = add, 1 = subtract
- `in_rnd`  in  3  rounding mode, passed unchanged to the core
- `add_a`, `add_b`  out  P_WORD  to core `a`, `b`
- `add_op`  out  1  to core `op`
- `add_rnd`  out  3  to core `rnd`
- `add_z`  in  P_WORD  from core `z`, combinational from `add_*`
- `add_status`  in  8  from core `status`: [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] reserved
- `out_vld`  out  1  result valid
- `out_rdy`  in  1  result consumed when `out_vld && out_rdy`
- `out_z`  out  P_WORD  result
- `out_status`  out  8  status captured with `out_z`
- `sticky`  out  8  OR of all captured statuses since reset or last clear
- `sticky_clr`  in  1  synchronous clear of `sticky`
- `res_cnt`  out  16  count of popped results, saturating

## Operation
- **Issue register** (`iss_vld`, `add_*`)
  - Loads on accept.
  - `in_rdy = !iss_vld || !fifo_full`; it does not depend on `out_rdy`.
- **Capture**
  - `cap = iss_vld && !fifo_full`.
  - On capture, `{add_z, add_status}` is pushed into the FIFO.
  - If there is no new accept in the same cycle, `iss_vld` clears.
  - While blocked, `add_*` hold stable, so the core output stays stable.
- **FIFO**
  - Show-ahead: `out_z`/`out_status` = entry at the read pointer; `out_vld = !empty`.
  - Pointers are `log2(P_DEPTH)+1` bits wide with a wrap bit. Full = MSBs differ and LSBs are equal.
- **Full FIFO with a pop:** the pop happens. The push is blocked that cycle; there is no same-cycle bypass.
- **Empty FIFO with a push:** the data appears the next cycle; there is no combinational bypass.
- **Sticky flags**
  - `sticky <= sticky_clr ? cap_status : sticky | cap_status`, where `cap_status = cap ? add_status : 0`.
  - A capture in the same cycle as a clear is therefore kept.
- **Counter:** `res_cnt` increments on each pop and holds at `16'hFFFF`.
- **Reset values:** `in_rdy` = 1 after reset release. All of `iss_vld`, `add_*`, `out_vld`, `out_z`, `out_status`, `sticky` and `res_cnt` = 0. FIFO pointers = 0.
- **Reset mid-operation:** all in-flight tokens and results are discarded; no partial outputs.

## Timing
- Accept at edge N → `add_*` valid after N → captured at N+1 (if not full) → `out_vld` after N+1.
- Minimum latency is 2 cycles.
- Sustained throughput is 1 token/cycle while `out_rdy` = 1.
- With `out_rdy` = 0, the block absorbs `P_DEPTH+1` tokens, then `in_rdy` = 0.
- `in_rdy` returns high the cycle after the first pop.
- Results leave in strict input order; no token is dropped or duplicated.

## Structure
- Package `fp_pkg`:
  - Defaults for `P_EXP`, `P_FRAC`, `P_BIAS`.
  - Status bit index constants: `ST_ZERO`, `ST_INF`, `ST_INVALID`, `ST_TINY`, `ST_HUGE`, `ST_INEXACT`.
  - Rounding mode constants: `RND_NEAREST_EVEN` = 0, `RND_ZERO` = 1.
- Sub-module `fp_res_fifo`: parameterised show-ahead FIFO (width `P_WORD+8`, depth `P_DEPTH`) providing full/empty.
- The core `ip_fp_addsub` is instantiated outside this block. The bench connects both.

## Test plan
- Basic add: single token `0x3C00 + 0x3C00`, op=0, rnd=0 → `out_z` = `0x4000`, `out_status` = 0, 2 cycles after accept; `res_cnt` = 1.
- Exact cancellation: `0x4000 - 0x4000`, op=1 → `out_z` = `0x0000`, `status[0]` = 1; `sticky[0]` = 1.
- Backpressure: hold `out_rdy` = 0 and stream 8 tokens → exactly 5 accepted, then `in_rdy` = 0. Release `out_rdy` → all results in order, none lost.
- Overflow flags: `0x7BFF + 0x7BFF` → inf/huge flags in `out_status`. Then assert `sticky_clr` in the same cycle as capture of `0x3C00 + 0x0001` → `sticky` shows only that result's inexact bit.
- Random stream: 1000 random operand pairs with random `in_vld`/`out_rdy` at 50% → every `out_z` matches the core reference model in order; `res_cnt` = 1000.
- Reset mid-stream: deassert `rst_n` with 3 results queued → `out_vld` = 0, `sticky` = 0, `res_cnt` = 0 immediately; after release, the first new token is the first result out.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg
// Shared constants and small helpers for the half-precision add/sub stream.
//   - Default format parameters (exponent, fraction, bias)
//   - Bit positions inside the core status byte
//   - Rounding mode encodings understood by the core
//   - Helper functions for sticky-flag update and a saturating counter
package fp_pkg;

    localparam int unsigned P_EXP_DEF  = 5;
    localparam int unsigned P_FRAC_DEF = 10;
    localparam int unsigned P_BIAS_DEF = 15;

    // Status byte layout; bits 7:6 are reserved and carried unchanged.
    localparam int unsigned ST_ZERO    = 0;
    localparam int unsigned ST_INF     = 1;
    localparam int unsigned ST_INVALID = 2;
    localparam int unsigned ST_TINY    = 3;
    localparam int unsigned ST_HUGE    = 4;
    localparam int unsigned ST_INEXACT = 5;

    localparam logic [2:0] RND_NEAREST_EVEN = 3'd0;
    localparam logic [2:0] RND_ZERO         = 3'd1;

    // A clear replaces the flags with this cycle's capture so a simultaneous
    // result is never lost.
    function automatic logic [7:0] sticky_next(
        input logic       clr,
        input logic [7:0] cur,
        input logic [7:0] cap_st
    );
        return clr ? cap_st : (cur | cap_st);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'h0001);
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// fp_res_fifo
// Show-ahead result FIFO. The entry at the read pointer is always presented
// on rd_data; a pop advances to the next entry on the following edge.
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write request (ignored while full)
//   pop                read advance (ignored while empty)
//   rd_data            entry at the read pointer
//   full, empty        occupancy status
module fp_res_fifo
    import fp_pkg::*;
#(
    parameter int unsigned P_WIDTH = 24,
    parameter int unsigned P_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = $clog2(P_DEPTH);

    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;
    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic               push_ok_s;
    logic               pop_ok_s;

    // Occupancy decode and show-ahead read port.
    always_comb begin
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty     = (wr_ptr_r == rd_ptr_r);
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        rd_data   = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Read and write pointers, each with a wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage; cleared on reset so an empty FIFO presents all-zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(P_DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fp_addsub_stream.sv
// fp_addsub_stream
// Streaming wrapper around an external combinational floating-point
// add/sub core. Operand tokens are taken over valid/ready into an issue
// register that drives the core; the core result and status are captured
// into a show-ahead FIFO and offered downstream over valid/ready.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_vld/in_rdy, in_a, in_b,
//   in_op, in_rnd                       operand token input
//   add_a, add_b, add_op, add_rnd       registered drive to the core
//   add_z, add_status                   core result (combinational from add_*)
//   out_vld/out_rdy, out_z, out_status  result output
//   sticky, sticky_clr                  accumulated status flags and clear
//   res_cnt                             saturating count of popped results
module fp_addsub_stream
    import fp_pkg::*;
#(
    parameter int unsigned P_EXP   = P_EXP_DEF,
    parameter int unsigned P_FRAC  = P_FRAC_DEF,
    parameter int unsigned P_BIAS  = P_BIAS_DEF,
    parameter int unsigned P_WORD  = 1 + P_EXP + P_FRAC,
    parameter int unsigned P_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [P_WORD-1:0] in_a,
    input  logic [P_WORD-1:0] in_b,
    input  logic              in_op,
    input  logic [2:0]        in_rnd,
    output logic [P_WORD-1:0] add_a,
    output logic [P_WORD-1:0] add_b,
    output logic              add_op,
    output logic [2:0]        add_rnd,
    input  logic [P_WORD-1:0] add_z,
    input  logic [7:0]        add_status,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [P_WORD-1:0] out_z,
    output logic [7:0]        out_status,
    output logic [7:0]        sticky,
    input  logic              sticky_clr,
    output logic [15:0]       res_cnt
);

    // The bias is interpreted only by the core; words pass through here
    // untouched, so a non-standard bias needs no special handling.
    if (P_BIAS != ((32'd1 << (P_EXP - 1)) - 32'd1)) begin : g_nonstd_bias
    end

    logic              iss_vld_r;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              accept_s;
    logic              cap_s;
    logic              pop_s;
    logic [7:0]        cap_status_s;
    logic [P_WORD+7:0] fifo_rd_s;

    // Handshake decode. Input readiness looks only at the issue register and
    // FIFO fullness, never at out_rdy, so there is no ready path through.
    always_comb begin
        in_rdy       = !iss_vld_r || !fifo_full_s;
        accept_s     = in_vld && in_rdy;
        cap_s        = iss_vld_r && !fifo_full_s;
        pop_s        = !fifo_empty_s && out_rdy;
        cap_status_s = cap_s ? add_status : 8'h00;
        out_vld      = !fifo_empty_s;
        out_z        = fifo_rd_s[P_WORD+7:8];
        out_status   = fifo_rd_s[7:0];
    end

    // Issue register: holds the token in front of the core until captured.
    // Operands stay put while blocked so the core output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld_r <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_op    <= 1'b0;
            add_rnd   <= 3'd0;
        end else if (accept_s) begin
            iss_vld_r <= 1'b1;
            add_a     <= in_a;
            add_b     <= in_b;
            add_op    <= in_op;
            add_rnd   <= in_rnd;
        end else if (cap_s) begin
            iss_vld_r <= 1'b0;
        end
    end

    // Sticky exception flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 8'h00;
        end else begin
            sticky <= sticky_next(sticky_clr, sticky, cap_status_s);
        end
    end

    // Count of results handed downstream, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt <= 16'h0000;
        end else if (pop_s) begin
            res_cnt <= sat_inc16(res_cnt);
        end
    end

    fp_res_fifo #(
        .P_WIDTH (P_WORD + 8),
        .P_DEPTH (P_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_s),
        .push_data ({add_z, add_status}),
        .pop       (pop_s),
        .rd_data   (fifo_rd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_fp_addsub_stream.sv
// tb_fp_addsub_stream
// Scoreboard bench for fp_addsub_stream. A behavioural half-precision
// add/sub model stands in for the external core and also produces the
// expected result for every accepted token.
module tb_fp_addsub_stream;
    import fp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_op;
    logic [2:0]  in_rnd;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_op;
    logic [2:0]  add_rnd;
    logic [15:0] add_z;
    logic [7:0]  add_status;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_z;
    logic [7:0]  out_status;
    logic [7:0]  sticky;
    logic        sticky_clr;
    logic [15:0] res_cnt;

    int          n_vec = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [23:0] sb_q[$];
    logic [23:0] core_s;
    logic [23:0] mon_exp;

    fp_addsub_stream #(
        .P_EXP   (5),
        .P_FRAC  (10),
        .P_BIAS  (15),
        .P_WORD  (16),
        .P_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_rnd     (in_rnd),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_op     (add_op),
        .add_rnd    (add_rnd),
        .add_z      (add_z),
        .add_status (add_status),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_z      (out_z),
        .out_status (out_status),
        .sticky     (sticky),
        .sticky_clr (sticky_clr),
        .res_cnt    (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Magnitude of a finite half in units of 2^-24 (smallest subnormal).
    function automatic longint hmag(input logic [15:0] x);
        longint f;
        int     e;
        f = longint'(x[9:0]);
        e = int'(x[14:10]);
        if (e == 0) return f;
        return (f + 64'sd1024) << (e - 1);
    endfunction

    // Half-precision a +/- b: exact integer sum, then a single rounding.
    // Returns {z[15:0], status[7:0]}.
    function automatic logic [23:0] fp_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic op, input logic [2:0] rnd);
        logic   sa, sb, an, bn, ai, bi, s;
        logic [7:0] st;
        longint sum, v, keep, rem, half;
        int     p, shift, field;
        st = 8'h00;
        sa = a[15];
        sb = b[15] ^ op;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        if (an || bn) begin
            st[ST_INVALID] = (an && !a[9]) || (bn && !b[9]);
            return {16'h7E00, st};
        end
        if (ai && bi && (sa != sb)) begin
            st[ST_INVALID] = 1'b1;
            return {16'h7E00, st};
        end
        if (ai || bi) begin
            st[ST_INF] = 1'b1;
            return {(ai ? sa : sb), 15'h7C00, st};
        end
        sum = (sa ? -hmag(a) : hmag(a)) + (sb ? -hmag(b) : hmag(b));
        if (sum == 0) begin
            st[ST_ZERO] = 1'b1;
            return {sa & sb, 15'h0000, st};
        end
        s = (sum < 0);
        v = s ? -sum : sum;
        if (v < 2048) begin
            st[ST_TINY] = (v < 1024);
            return {s, 5'(v >> 10), 10'(v), st};
        end
        p = 0;
        for (int i = 0; i < 63; i++) if (v[i]) p = i;
        shift = p - 10;
        keep  = v >> shift;
        rem   = v - (keep << shift);
        half  = 64'sd1 << (shift - 1);
        if (rnd != RND_ZERO && (rem > half || (rem == half && keep[0]))) keep = keep + 1;
        if (keep == 2048) begin
            keep  = 1024;
            shift = shift + 1;
        end
        field = shift + 1;
        if (field >= 31) begin
            st[ST_HUGE]    = 1'b1;
            st[ST_INEXACT] = 1'b1;
            if (rnd == RND_ZERO) return {s, 15'h7BFF, st};
            st[ST_INF] = 1'b1;
            return {s, 15'h7C00, st};
        end
        st[ST_INEXACT] = (rem != 0);
        return {s, 5'(field), 10'(keep), st};
    endfunction

    // Stand-in for the external combinational core.
    always_comb core_s = fp_ref(add_a, add_b, add_op, add_rnd);
    assign add_z      = core_s[23:8];
    assign add_status = core_s[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected response for every token accepted at the next edge.
    always @(negedge clk) begin
        if (rst_n && in_vld && in_rdy) begin
            sb_q.push_back(fp_ref(in_a, in_b, in_op, in_rnd));
            n_vec++;
        end
    end

    // Monitor: compare every result consumed downstream, in order.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_output: actual z=0x%0h, required no output", out_z);
            end else begin
                mon_exp = sb_q.pop_front();
                check("out_z", 32'(out_z), 32'(mon_exp[23:8]));
                check("out_status", 32'(out_status), 32'(mon_exp[7:0]));
            end
        end
    end

    // Offer one token and wait (bounded) until it is taken.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic [2:0] rnd);
        int g;
        @(posedge clk); #1;
        in_vld = 1'b1; in_a = a; in_b = b; in_op = op; in_rnd = rnd;
        g = 0;
        @(negedge clk);
        while (!in_rdy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_rdy) check("send_timeout", 32'(in_rdy), 32'd1);
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    // Random tokens with 50% valid and 50% downstream ready.
    task automatic drive_random(input int n);
        int sent;
        int guard;
        bit took;
        sent = 0; guard = 0; took = 1'b0;
        while (sent < n && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
            if (!in_vld || took) begin
                in_vld = ($urandom_range(0, 1) == 1);
                in_a   = 16'($urandom);
                in_b   = 16'($urandom);
                in_op  = 1'($urandom_range(0, 1));
                in_rnd = 3'($urandom_range(0, 1));
            end
            out_rdy = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            took = in_vld && in_rdy;
            if (took) sent++;
        end
        @(posedge clk); #1;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        if (sent < n) check("random_timeout", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int g;
        logic [15:0] bp_a [8];
        logic [15:0] bp_b [8];
        rst_n = 1'b0; in_vld = 1'b0; in_a = 16'h0; in_b = 16'h0; in_op = 1'b0;
        in_rnd = 3'd0; out_rdy = 1'b0; sticky_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_z", 32'(out_z), 32'd0);
        check("rst_out_status", 32'(out_status), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_res_cnt", 32'(res_cnt), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);

        // Basic add: 1.0 + 1.0 = 2.0, visible two cycles after accept.
        out_rdy = 1'b1;
        send(16'h3C00, 16'h3C00, 1'b0, RND_NEAREST_EVEN);
        @(negedge clk);
        check("lat_out_vld_early", 32'(out_vld), 32'd0);
        @(negedge clk);
        check("basic_out_vld", 32'(out_vld), 32'd1);
        check("basic_out_z", 32'(out_z), 32'h4000);
        check("basic_out_status", 32'(out_status), 32'h00);
        @(negedge clk);
        check("basic_res_cnt", 32'(res_cnt), 32'd1);
        check("basic_out_vld_after", 32'(out_vld), 32'd0);

        // Exact cancellation: zero flag in result and sticky.
        send(16'h4000, 16'h4000, 1'b1, RND_NEAREST_EVEN);
        @(negedge clk);
        @(negedge clk);
        check("cancel_out_z", 32'(out_z), 32'h0000);
        check("cancel_out_status", 32'(out_status), 32'h01);
        @(negedge clk);
        check("cancel_sticky", 32'(sticky), 32'h01);

        // Backpressure: five tokens absorbed with out_rdy low.
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = 16'h3C00 + 16'(i);
            bp_b[i] = 16'($urandom_range(0, 16'h7BFF));
        end
        out_rdy = 1'b0;
        idx = 0;
        @(posedge clk); #1;
        in_vld = 1'b1; in_a = bp_a[0]; in_b = bp_b[0]; in_op = 1'b0; in_rnd = RND_NEAREST_EVEN;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_vld && in_rdy) idx++;
            @(posedge clk); #1;
            if (idx < 8) begin
                in_a = bp_a[idx]; in_b = bp_b[idx];
            end else begin
                in_vld = 1'b0;
            end
        end
        @(negedge clk);
        check("bp_accepted", 32'(idx), 32'd5);
        check("bp_in_rdy_low", 32'(in_rdy), 32'd0);
        @(posedge clk); #1;
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_in_rdy_at_pop", 32'(in_rdy), 32'd0);
        @(negedge clk);
        check("bp_in_rdy_after_pop", 32'(in_rdy), 32'd1);
        if (in_vld && in_rdy) idx++;
        g = 0;
        while (idx < 8 && g < 100) begin
            @(posedge clk); #1;
            in_a = bp_a[idx]; in_b = bp_b[idx];
            @(negedge clk);
            if (in_vld && in_rdy) idx++;
            g++;
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd8);
        drain();

        // Overflow to infinity, then a clear coinciding with a capture.
        send(16'h7BFF, 16'h7BFF, 1'b0, RND_NEAREST_EVEN);
        @(negedge clk);
        @(negedge clk);
        check("ovf_out_z", 32'(out_z), 32'h7C00);
        check("ovf_out_status", 32'(out_status), 32'h32); // inf | huge | inexact
        @(negedge clk);
        check("ovf_sticky", 32'(sticky), 32'h33);
        @(posedge clk); #1;
        in_vld = 1'b1; in_a = 16'h3C00; in_b = 16'h0001; in_op = 1'b0; in_rnd = RND_NEAREST_EVEN;
        @(negedge clk);
        check("clr_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        check("clr_sticky", 32'(sticky), 32'h20);
        check("clr_out_z", 32'(out_z), 32'h3C00);
        check("clr_out_status", 32'(out_status), 32'h20);
        @(negedge clk);

        // Reset with three results queued.
        out_rdy = 1'b0;
        send(16'h3C00, 16'h3C00, 1'b0, RND_NEAREST_EVEN);
        send(16'h4000, 16'h3C00, 1'b0, RND_NEAREST_EVEN);
        send(16'h4200, 16'h3C00, 1'b0, RND_ZERO);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_out_vld", 32'(out_vld), 32'd1);
        check("pre_rst_res_cnt", 32'(res_cnt), 32'd12);
        check("pre_rst_sticky", 32'(sticky), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_vld", 32'(out_vld), 32'd0);
        check("mid_rst_sticky", 32'(sticky), 32'd0);
        check("mid_rst_res_cnt", 32'(res_cnt), 32'd0);
        check("mid_rst_out_z", 32'(out_z), 32'd0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        out_rdy = 1'b1;
        send(16'h4400, 16'hC000, 1'b0, RND_NEAREST_EVEN);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_out_vld", 32'(out_vld), 32'd1);
        check("post_rst_out_z", 32'(out_z), 32'h4000); // 4 + (-2)
        @(negedge clk);
        check("post_rst_res_cnt", 32'(res_cnt), 32'd1);

        // Random stream from a clean reset.
        @(negedge clk) rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        drive_random(1000);
        drain();
        check("rand_res_cnt", 32'(res_cnt), 32'd1000);
        check("rand_out_vld", 32'(out_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
